// File: rtl/seq_detector_10110.sv
// Serial sequence detector for PATTERN (MSB received first) with saturating match and period counters.
// Optional feature: define SEQDET_OVERLAP_EN to count overlapping matches.
module seq_detector_10110 #(
  parameter logic [4:0] PATTERN = 5'b10110,
  parameter int         CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             period_tick,
  input  logic             clear,
  output logic             det_pulse,
  output logic [2:0]       state_out,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             cnt_sat
);

  typedef enum logic [2:0] {S0, S1, S2, S3, S4} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Longest suffix (at most 4 bits) of (matched prefix + b) that is also a pattern prefix.
  function automatic state_t advance(input logic [2:0] n, input logic b);
    logic [4:0] c;
    logic [2:0] best;
    logic       ok;
    int         len;
    c    = '0;
    best = '0;
    len  = int'(n) + 1;
    for (int i = 0; i < 5; i++)
      c[3'(i)] = (i < int'(n)) ? PATTERN[3'(4 - i)] : b;
    for (int k = 1; k <= 4; k++) begin
      if (k <= len) begin
        ok = 1'b1;
        for (int j = 0; j < 4; j++)
          if (j < k)
            if (c[3'(len - k + j)] != PATTERN[3'(4 - j)]) ok = 1'b0;
        if (ok) best = 3'(k);
      end
    end
    return state_t'(best);
  endfunction

  state_t           state;
  logic             hit;
  state_t           reentry;
  logic [CNT_W-1:0] cnt_next;

  assign hit = bit_valid && (state == S4) && (bit_in == PATTERN[0]);

`ifdef SEQDET_OVERLAP_EN
  // Feeding the final bit from S4 yields the longest proper suffix that is a prefix.
  assign reentry = advance(3'd4, PATTERN[0]);
`else
  assign reentry = S0;
`endif

  assign cnt_next  = (hit && match_cnt != CNT_MAX) ? match_cnt + 1'b1 : match_cnt;
  assign state_out = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S0;
      det_pulse  <= 1'b0;
      match_cnt  <= '0;
      period_cnt <= '0;
      cnt_sat    <= 1'b0;
    end else if (clear) begin
      state     <= S0;
      det_pulse <= 1'b0;
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
    end else begin
      det_pulse <= hit;
      if (bit_valid) state <= hit ? reentry : advance(state, bit_in);
      if (period_tick) begin
        period_cnt <= cnt_next;
        match_cnt  <= '0;
        cnt_sat    <= 1'b0;
      end else begin
        match_cnt <= cnt_next;
        cnt_sat   <= (cnt_next == CNT_MAX);
      end
    end
  end

endmodule

// File: tb/tb_seq_detector_10110.sv
// Directed bench for seq_detector_10110: per-step det/state expectations queued and popped after each edge.
module tb_seq_detector_10110;

  localparam int CNT_W = 4;
`ifdef SEQDET_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif
  localparam logic [2:0] AFTER_DET = OVL ? 3'd2 : 3'd0;

  logic             clk = 1'b0;
  logic             rst_n, bit_in, bit_valid, period_tick, clear;
  logic             det_pulse, cnt_sat;
  logic [2:0]       state_out;
  logic [CNT_W-1:0] match_cnt, period_cnt;

  seq_detector_10110 #(.PATTERN(5'b10110), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .period_tick(period_tick), .clear(clear), .det_pulse(det_pulse),
    .state_out(state_out), .match_cnt(match_cnt), .period_cnt(period_cnt),
    .cnt_sat(cnt_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       det;
    logic       chk_st;
    logic [2:0] st;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    total++;
    assert (obs === req) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
  endtask

  // One clock: drive inputs, queue the expectation, compare once the edge has been taken.
  task automatic step(input logic b, input logic v, input logic tk, input logic clr,
                      input logic ed, input logic cs, input logic [2:0] es, input string tag);
    exp_t e;
    bit_in = b; bit_valid = v; period_tick = tk; clear = clr;
    exp_q.push_back('{det: ed, chk_st: cs, st: es, tag: tag});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({e.tag, "_det"}, 32'(det_pulse), 32'(e.det));
    if (e.chk_st) check({e.tag, "_state"}, 32'(state_out), 32'(e.st));
    bit_valid = 1'b0; period_tick = 1'b0; clear = 1'b0;
  endtask

  // Full pattern; intermediate states depend on overlap mode so only det is checked.
  task automatic send_pat(input logic tick_last, input string tag);
    step(1, 1, 0, 0, 0, 0, 0, tag);
    step(0, 1, 0, 0, 0, 0, 0, tag);
    step(1, 1, 0, 0, 0, 0, 0, tag);
    step(1, 1, 0, 0, 0, 0, 0, tag);
    step(0, 1, tick_last, 0, 1, 1, AFTER_DET, tag);
  endtask

  initial begin
    rst_n = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; period_tick = 1'b0; clear = 1'b0;

    // Reset held for two cycles
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'(state_out), 0);
    check("rst_det", 32'(det_pulse), 0);
    check("rst_match", 32'(match_cnt), 0);
    check("rst_period", 32'(period_cnt), 0);
    check("rst_sat", 32'(cnt_sat), 0);
    rst_n = 1'b1;

    // Overlap sequence 1,0,1,1,0,1,1,0
    step(1, 1, 0, 0, 0, 1, 3'd1, "ovl_b1");
    step(0, 1, 0, 0, 0, 1, 3'd2, "ovl_b2");
    step(1, 1, 0, 0, 0, 1, 3'd3, "ovl_b3");
    step(1, 1, 0, 0, 0, 1, 3'd4, "ovl_b4");
    step(0, 1, 0, 0, 1, 1, AFTER_DET, "ovl_b5");
    step(1, 1, 0, 0, 0, 1, OVL ? 3'd3 : 3'd1, "ovl_b6");
    step(1, 1, 0, 0, 0, 1, OVL ? 3'd4 : 3'd1, "ovl_b7");
    step(0, 1, 0, 0, OVL, 1, 3'd2, "ovl_b8");
    check("ovl_match", 32'(match_cnt), OVL ? 2 : 1);

    step(0, 0, 0, 1, 0, 1, 3'd0, "clr1");
    check("clr1_match", 32'(match_cnt), 0);

    // Valid gaps with bit_in toggling
    step(1, 1, 0, 0, 0, 1, 3'd1, "gap_b1");
    step(0, 1, 0, 0, 0, 1, 3'd2, "gap_b2");
    step(1, 0, 0, 0, 0, 1, 3'd2, "gap_h1");
    step(0, 0, 0, 0, 0, 1, 3'd2, "gap_h2");
    step(1, 0, 0, 0, 0, 1, 3'd2, "gap_h3");
    step(1, 1, 0, 0, 0, 1, 3'd3, "gap_b3");
    step(1, 1, 0, 0, 0, 1, 3'd4, "gap_b4");
    step(0, 1, 0, 0, 1, 1, AFTER_DET, "gap_b5");
    step(0, 0, 0, 0, 0, 1, AFTER_DET, "gap_idle");
    check("gap_match", 32'(match_cnt), 1);

    // Detection and period_tick on the same edge
    step(0, 0, 0, 1, 0, 1, 3'd0, "clr2");
    for (int i = 0; i < 6; i++) send_pat(1'b0, "pre6");
    check("pre6_match", 32'(match_cnt), 6);
    send_pat(1'b1, "simul");
    check("simul_period", 32'(period_cnt), 7);
    check("simul_match", 32'(match_cnt), 0);
    check("simul_sat", 32'(cnt_sat), 0);

    // Saturation at 2^CNT_W-1
    step(0, 0, 0, 1, 0, 1, 3'd0, "clr3");
    check("clr3_period_kept", 32'(period_cnt), 7);
    for (int i = 0; i < 14; i++) send_pat(1'b0, "sat");
    check("sat14_match", 32'(match_cnt), 14);
    check("sat14_flag", 32'(cnt_sat), 0);
    send_pat(1'b0, "sat15");
    check("sat15_match", 32'(match_cnt), 15);
    check("sat15_flag", 32'(cnt_sat), 1);
    send_pat(1'b0, "sat16");
    check("sat16_match", 32'(match_cnt), 15);
    check("sat16_flag", 32'(cnt_sat), 1);
    step(0, 0, 1, 0, 0, 1, AFTER_DET, "tick_idle");
    check("tick_period", 32'(period_cnt), 15);
    check("tick_match", 32'(match_cnt), 0);
    check("tick_sat", 32'(cnt_sat), 0);

    // Mid-pattern clear: bit_in and period_tick ignored, period_cnt retained
    step(0, 0, 0, 1, 0, 1, 3'd0, "clr4");
    step(1, 1, 0, 0, 0, 1, 3'd1, "mc_b1");
    step(0, 1, 0, 0, 0, 1, 3'd2, "mc_b2");
    step(1, 1, 0, 0, 0, 1, 3'd3, "mc_b3");
    step(1, 1, 1, 1, 0, 1, 3'd0, "mc_clear");
    check("mc_period", 32'(period_cnt), 15);
    check("mc_match", 32'(match_cnt), 0);
    step(1, 1, 0, 0, 0, 1, 3'd1, "mc_a1");
    step(0, 1, 0, 0, 0, 1, 3'd2, "mc_a2");
    step(1, 1, 0, 0, 0, 1, 3'd3, "mc_a3");
    step(1, 1, 0, 0, 0, 1, 3'd4, "mc_a4");
    step(0, 1, 0, 0, 1, 1, AFTER_DET, "mc_a5");
    check("mc_after_match", 32'(match_cnt), 1);

    // Mid-pattern reset
    step(0, 0, 0, 1, 0, 1, 3'd0, "clr5");
    step(1, 1, 0, 0, 0, 1, 3'd1, "mr_b1");
    step(0, 1, 0, 0, 0, 1, 3'd2, "mr_b2");
    step(1, 1, 0, 0, 0, 1, 3'd3, "mr_b3");
    rst_n = 1'b0; bit_in = 1'b1; bit_valid = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1; bit_valid = 1'b0;
    check("mr_state", 32'(state_out), 0);
    check("mr_period", 32'(period_cnt), 0);
    check("mr_match", 32'(match_cnt), 0);
    check("mr_det", 32'(det_pulse), 0);
    step(1, 1, 0, 0, 0, 1, 3'd1, "mr_a1");
    step(0, 1, 0, 0, 0, 1, 3'd2, "mr_a2");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
